// File: rtl/washer_plant_sensor_unit_pkg.sv
// Shared definitions for the washer plant sensor model: detergent dispenser states.
package washer_plant_sensor_unit_pkg;

  typedef enum logic [1:0] {
    DET_IDLE = 2'd0,
    DET_WAIT = 2'd1,
    DET_DONE = 2'd2
  } det_state_t;

endpackage

// File: rtl/washer_event_timer.sv
// Saturating up-counter that fires a one-cycle registered pulse on the N-th
// consecutive enabled edge and then holds until enable drops or clr is seen.
module washer_event_timer #(
  parameter int N = 32,
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic pulse
);

  localparam logic [W-1:0] TERMINAL = W'(N);

  logic [W-1:0] count;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      pulse <= 1'b0;
    end else if (clr || !en) begin
      count <= '0;
      pulse <= 1'b0;
    end else if (count != TERMINAL) begin
      count <= count + W'(1);
      pulse <= (count == TERMINAL - W'(1));
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/washer_plant_sensor_unit.sv
// Plant-side model of the washing machine: water level, detergent dispenser and
// wash/spin timers driven by the controller's actuator commands.
module washer_plant_sensor_unit
  import washer_plant_sensor_unit_pkg::*;
#(
  parameter int LEVEL_W     = 8,
  parameter int FULL_LEVEL  = 16,
  parameter int FILL_RATE   = 1,
  parameter int DRAIN_RATE  = 2,
  parameter int TMR_W       = 16,
  parameter int DET_DELAY   = 4,
  parameter int WASH_CYCLES = 32,
  parameter int SPIN_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Motor_on,
  input  logic Fill_valve_on,
  input  logic Drained_valve_on,
  input  logic Door_Lock,
  input  logic Done,
  output logic Filled,
  output logic Drained,
  output logic Detergent_Added,
  output logic Cycle_Timeout,
  output logic Spin_Timeout,
  output logic Valve_Conflict
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;
  localparam logic [LEVEL_W-1:0] FILL_STEP = LEVEL_W'(FILL_RATE);
  localparam logic [LEVEL_W-1:0] DRAIN_STEP = LEVEL_W'(DRAIN_RATE);
  localparam logic [LEVEL_W-1:0] FULL = LEVEL_W'(FULL_LEVEL);
  localparam logic [TMR_W-1:0] DET_LOAD = TMR_W'(DET_DELAY);

  logic [LEVEL_W-1:0] level, level_next;
  logic               filled_rise;
  logic               valves_both;

  det_state_t         det_state, det_state_next;
  logic [TMR_W-1:0]   det_cnt, det_cnt_next;
  logic               det_pulse_next;

  assign valves_both = Fill_valve_on && Drained_valve_on;

  // NOTE: every signal driven in always_comb gets a default first, otherwise a
  // path that leaves it unassigned infers a latch.
  always_comb begin
    level_next = level;
    if (Fill_valve_on && !Drained_valve_on) begin
      level_next = (level > LEVEL_MAX - FILL_STEP) ? LEVEL_MAX : level + FILL_STEP;
    end else if (Drained_valve_on && !Fill_valve_on) begin
      level_next = (level < DRAIN_STEP) ? '0 : level - DRAIN_STEP;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      level          <= '0;
      Valve_Conflict <= 1'b0;
    end else begin
      level <= level_next;
      if (valves_both) Valve_Conflict <= 1'b1;
    end
  end

  assign Filled  = (level >= FULL);
  assign Drained = (level == '0);

  // Rise is taken on the edge that carries the level across the threshold.
  assign filled_rise = (level_next >= FULL) && !Filled;

  always_comb begin
    det_state_next = det_state;
    det_cnt_next   = det_cnt;
    det_pulse_next = 1'b0;
    if (Done) begin
      det_state_next = DET_IDLE;
      det_cnt_next   = '0;
    end else begin
      case (det_state)
        DET_IDLE: begin
          if (filled_rise && Door_Lock) begin
            det_state_next = DET_WAIT;
            det_cnt_next   = DET_LOAD;
          end
        end
        DET_WAIT: begin
          if (!Door_Lock) begin
            det_state_next = DET_IDLE;
            det_cnt_next   = '0;
          end else if (det_cnt <= TMR_W'(1)) begin
            det_state_next = DET_DONE;
            det_cnt_next   = '0;
            det_pulse_next = 1'b1;
          end else begin
            det_cnt_next = det_cnt - TMR_W'(1);
          end
        end
        DET_DONE: begin
          if (Drained) det_state_next = DET_IDLE;
        end
        default: begin
          det_state_next = DET_IDLE;
          det_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      det_state       <= DET_IDLE;
      det_cnt         <= '0;
      Detergent_Added <= 1'b0;
    end else begin
      det_state       <= det_state_next;
      det_cnt         <= det_cnt_next;
      Detergent_Added <= det_pulse_next;
    end
  end

  washer_event_timer #(
    .N (WASH_CYCLES),
    .W (TMR_W)
  ) u_wash_timer (
    .clk   (Clock),
    .rst   (Reset),
    .en    (Motor_on && !Drained_valve_on && Door_Lock),
    .clr   (Done),
    .pulse (Cycle_Timeout)
  );

  washer_event_timer #(
    .N (SPIN_CYCLES),
    .W (TMR_W)
  ) u_spin_timer (
    .clk   (Clock),
    .rst   (Reset),
    .en    (Motor_on && Drained_valve_on && Door_Lock),
    .clr   (Done),
    .pulse (Spin_Timeout)
  );

endmodule

// File: tb/tb_washer_plant_sensor_unit.sv
// Self-checking bench for washer_plant_sensor_unit: directed scenarios followed by
// randomized actuator traffic, all scored against an edge-by-edge behavioural model.
module tb_washer_plant_sensor_unit;

  localparam int LEVEL_W     = 8;
  localparam int LEVEL_MAX   = (1 << LEVEL_W) - 1;
  localparam int FULL_LEVEL  = 16;
  localparam int FILL_RATE   = 1;
  localparam int DRAIN_RATE  = 2;
  localparam int TMR_W       = 16;
  localparam int DET_DELAY   = 4;
  localparam int WASH_CYCLES = 32;
  localparam int SPIN_CYCLES = 16;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Motor_on = 1'b0;
  logic Fill_valve_on = 1'b0;
  logic Drained_valve_on = 1'b0;
  logic Door_Lock = 1'b0;
  logic Done = 1'b0;
  logic Filled, Drained, Detergent_Added, Cycle_Timeout, Spin_Timeout, Valve_Conflict;

  washer_plant_sensor_unit #(
    .LEVEL_W     (LEVEL_W),
    .FULL_LEVEL  (FULL_LEVEL),
    .FILL_RATE   (FILL_RATE),
    .DRAIN_RATE  (DRAIN_RATE),
    .TMR_W       (TMR_W),
    .DET_DELAY   (DET_DELAY),
    .WASH_CYCLES (WASH_CYCLES),
    .SPIN_CYCLES (SPIN_CYCLES)
  ) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .Motor_on         (Motor_on),
    .Fill_valve_on    (Fill_valve_on),
    .Drained_valve_on (Drained_valve_on),
    .Door_Lock        (Door_Lock),
    .Done             (Done),
    .Filled           (Filled),
    .Drained          (Drained),
    .Detergent_Added  (Detergent_Added),
    .Cycle_Timeout    (Cycle_Timeout),
    .Spin_Timeout     (Spin_Timeout),
    .Valve_Conflict   (Valve_Conflict)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model state: plain water volume, run lengths of enabled edges, and the
  // edge number at which the detergent dose is due.
  int m_level;
  bit m_conflict;
  int m_wash_run;
  int m_spin_run;
  bit m_armed;
  bit m_pending;
  int m_due;
  int edge_no = 0;
  bit e_det, e_cycle, e_spin;

  task automatic model_reset();
    m_level    = 0;
    m_conflict = 1'b0;
    m_wash_run = 0;
    m_spin_run = 0;
    m_armed    = 1'b1;
    m_pending  = 1'b0;
    m_due      = 0;
    e_det      = 1'b0;
    e_cycle    = 1'b0;
    e_spin     = 1'b0;
  endtask

  task automatic model_edge();
    bit was_full, was_empty, now_full;
    edge_no++;
    was_full  = (m_level >= FULL_LEVEL);
    was_empty = (m_level == 0);
    if (Fill_valve_on && Drained_valve_on) m_conflict = 1'b1;
    else if (Fill_valve_on) m_level = (m_level + FILL_RATE > LEVEL_MAX) ? LEVEL_MAX : m_level + FILL_RATE;
    else if (Drained_valve_on) m_level = (m_level < DRAIN_RATE) ? 0 : m_level - DRAIN_RATE;
    now_full = (m_level >= FULL_LEVEL);

    e_cycle = 1'b0;
    e_spin  = 1'b0;
    e_det   = 1'b0;
    if (Done || !(Motor_on && !Drained_valve_on && Door_Lock)) m_wash_run = 0;
    else begin
      m_wash_run++;
      e_cycle = (m_wash_run == WASH_CYCLES);
    end
    if (Done || !(Motor_on && Drained_valve_on && Door_Lock)) m_spin_run = 0;
    else begin
      m_spin_run++;
      e_spin = (m_spin_run == SPIN_CYCLES);
    end

    if (Done) begin
      m_pending = 1'b0;
      m_armed   = 1'b1;
    end else if (m_pending) begin
      if (!Door_Lock) begin
        m_pending = 1'b0;
        m_armed   = 1'b1;
      end else if (edge_no == m_due) begin
        e_det     = 1'b1;
        m_pending = 1'b0;
      end
    end else if (!m_armed) begin
      if (was_empty) m_armed = 1'b1;
    end else if (now_full && !was_full && Door_Lock) begin
      m_pending = 1'b1;
      m_armed   = 1'b0;
      m_due     = edge_no + DET_DELAY;
    end
  endtask

  function automatic logic [5:0] expected();
    return {m_level >= FULL_LEVEL, m_level == 0, e_det, e_cycle, e_spin, m_conflict};
  endfunction

  task automatic check(input string tag);
    logic [5:0] obs, exp;
    obs = {Filled, Drained, Detergent_Added, Cycle_Timeout, Spin_Timeout, Valve_Conflict};
    exp = expected();
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s edge=%0d observed={Fil,Drn,Det,Cyc,Spn,Cnf}=%b expected=%b",
             tag, edge_no, obs, exp);
    end
  endtask

  // Called at a negedge; drives inputs, takes one rising edge, checks, and
  // returns at the following negedge.
  task automatic step(input logic mo, input logic fi, input logic dr,
                      input logic lk, input logic dn, input string tag);
    Motor_on         = mo;
    Fill_valve_on    = fi;
    Drained_valve_on = dr;
    Door_Lock        = lk;
    Done             = dn;
    @(posedge Clock);
    model_edge();
    #1;
    check(tag);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset            = 1'b1;
    Motor_on         = 1'b0;
    Fill_valve_on    = 1'b0;
    Drained_valve_on = 1'b0;
    Door_Lock        = 1'b0;
    Done             = 1'b0;
    #1;
    model_reset();
    check("reset_state");
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Reset pulse that lands between rising edges while inputs stay active.
  task automatic async_reset(input string tag);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check(tag);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    logic mo, fi, dr, lk, dn;
    int r;

    do_reset();

    // Fill to threshold, then keep filling to show saturation, then empty.
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, "fill_to_full");
    for (int i = 0; i < 250; i++) step(0, 1, 0, 0, 0, "fill_saturate");
    for (int i = 0; i < 130; i++) step(0, 0, 1, 0, 0, "drain_to_empty");

    // Detergent dose on first fill, none on a partial refill, a second after full drain.
    do_reset();
    for (int i = 0; i < 24; i++) step(0, 1, 0, 1, 0, "det_first_fill");
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0, "det_partial_drain");
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1, 0, "det_partial_refill");
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0, "det_full_drain");
    for (int i = 0; i < 22; i++) step(0, 1, 0, 1, 0, "det_second_fill");
    // Door opening while the dose is pending cancels it.
    for (int i = 0; i < 16; i++) step(0, 0, 1, 1, 0, "det_drain_again");
    for (int i = 0; i < 17; i++) step(0, 1, 0, 1, 0, "det_cancel_fill");
    step(0, 1, 0, 0, 0, "det_cancel_unlock");
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 0, "det_cancel_after");

    // Wash timeout, then interrupted run needing a full count again.
    do_reset();
    for (int i = 0; i < 40; i++) step(1, 0, 0, 1, 0, "wash_run");
    step(0, 0, 0, 1, 0, "wash_stop");
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 0, "wash_partial");
    step(0, 0, 0, 1, 0, "wash_drop");
    for (int i = 0; i < 40; i++) step(1, 0, 0, 1, 0, "wash_restart");

    // Spin from full level: empty after 8 edges, timeout after 16.
    do_reset();
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, "spin_prefill");
    for (int i = 0; i < 20; i++) step(1, 0, 1, 1, 0, "spin_run");

    // Both valves: level holds, conflict latches until reset.
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, "conflict_prefill");
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, "conflict_both");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, "conflict_sticky");
    do_reset();

    // Async reset mid-spin, then timeouts suppressed by door or Done at the terminal edge.
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, "arst_prefill");
    for (int i = 0; i < 5; i++) step(1, 0, 1, 1, 0, "arst_spin");
    async_reset("arst_mid_spin");
    for (int i = 0; i < 31; i++) step(1, 0, 0, 1, 0, "wash_to_unlock");
    step(1, 0, 0, 0, 0, "wash_unlock_terminal");
    for (int i = 0; i < 31; i++) step(1, 0, 0, 1, 0, "wash_to_done");
    step(1, 0, 0, 1, 1, "wash_done_terminal");
    for (int i = 0; i < 15; i++) step(1, 0, 1, 1, 0, "spin_to_done");
    step(1, 0, 1, 1, 1, "spin_done_terminal");
    for (int i = 0; i < 15; i++) step(1, 0, 1, 1, 0, "spin_to_unlock");
    step(1, 0, 1, 0, 0, "spin_unlock_terminal");

    // Randomized traffic: inputs are sticky and change occasionally so long runs occur.
    mo = 1'b0; fi = 1'b0; dr = 1'b0; lk = 1'b1; dn = 1'b0;
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 11) == 0) mo = ~mo;
        if ($urandom_range(0, 15) == 0) lk = ~lk;
        if ($urandom_range(0, 9) == 0) begin
          r = int'($urandom_range(0, 39));
          fi = (r < 18) || (r == 39);
          dr = (r >= 18 && r < 34) || (r == 39);
        end
        dn = ($urandom_range(0, 49) == 0);
        step(mo, fi, dr, lk, dn, "random");
        if (seg % 2 == 1 && i == 75) async_reset("random_async_reset");
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
